// File: rtl/memory_controller_if.sv
// Bus bundle between the core pipeline, the memory controller and the word memory.
// The controller sits on the slave modport. The master modport is the core
// pipeline side together with the memory, which returns mem_output_data.
interface memory_controller_if;
    // instruction-fetch port
    logic        inst_req;
    logic [31:0] inst_address;
    logic        inst_ack;
    logic [31:0] inst_data;
    logic        inst_err;

    // load/store data port
    logic        data_req;
    logic        data_write;
    logic [1:0]  data_size;
    logic        data_unsigned;
    logic [31:0] data_address;
    logic [31:0] data_wdata;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic        data_err;

    // memory side
    logic [31:0] mem_address;
    logic [31:0] mem_input_data;
    logic        mem_should_write;
    logic [31:0] mem_output_data;

    modport slave (
        input  inst_req, inst_address,
        output inst_ack, inst_data, inst_err,
        input  data_req, data_write, data_size, data_unsigned, data_address, data_wdata,
        output data_ack, data_rdata, data_err,
        output mem_address, mem_input_data, mem_should_write,
        input  mem_output_data
    );

    modport master (
        output inst_req, inst_address,
        input  inst_ack, inst_data, inst_err,
        output data_req, data_write, data_size, data_unsigned, data_address, data_wdata,
        input  data_ack, data_rdata, data_err,
        input  mem_address, mem_input_data, mem_should_write,
        output mem_output_data
    );
endinterface

// File: rtl/memory_controller.sv
// Memory controller: round-robin arbitration between the fetch and load/store
// ports onto a single-port word memory (registered read on the rising edge,
// write on the falling edge). Handles sub-word loads with extension, sub-word
// stores by read-modify-write, and rejects misaligned/out-of-range accesses.
module memory_controller #(
    parameter int unsigned MEM_SIZE_WORDS = 256
) (
    input  logic             clock,
    input  logic             reset,
    memory_controller_if.slave bus
);

    localparam logic [33:0] MEM_LIMIT = 34'(MEM_SIZE_WORDS) * 34'd4;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RESP,
        WRITE,
        RMW_READ,
        RMW_WRITE,
        ERR
    } state_t;

    state_t      state;
    logic        grant_inst;       // 1 = current access belongs to the fetch port
    logic        last_grant_inst;  // 1 = last grant went to fetch, 0 = data
    logic [1:0]  addr_lo_q;        // byte lane of the latched address
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] wdata_q;

    logic        inst_ack_q;
    logic        inst_err_q;
    logic        data_ack_q;
    logic        data_err_q;
    logic [31:0] mem_address_q;
    logic        mem_write_q;

    // arbitration / error-check results for the current IDLE cycle
    logic        pick_inst;
    logic        pick_data;
    logic [31:0] sel_addr;
    logic        out_of_range;
    logic        sel_err;

    // datapath values that depend on the memory's registered output
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_value;
    logic [4:0]  lane_shift;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] merged_word;

    // Round-robin pick of a requester and the error check for its request.
    always_comb begin
        pick_inst    = bus.inst_req && (!bus.data_req || !last_grant_inst);
        pick_data    = bus.data_req && !pick_inst;
        sel_addr     = pick_inst ? bus.inst_address : bus.data_address;
        out_of_range = ({2'b00, sel_addr} >= MEM_LIMIT);
        if (pick_inst) begin
            sel_err = (sel_addr[1:0] != 2'b00) || out_of_range;
        end else begin
            case (bus.data_size)
                2'b00:   sel_err = out_of_range;
                2'b01:   sel_err = sel_addr[0] || out_of_range;
                2'b10:   sel_err = (sel_addr[1:0] != 2'b00) || out_of_range;
                default: sel_err = 1'b1;
            endcase
        end
    end

    // Access sequencer; acks, errors and memory controls are registered so
    // they appear in the cycle of the state that owns them.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            grant_inst      <= 1'b0;
            last_grant_inst <= 1'b0;
            addr_lo_q       <= '0;
            size_q          <= '0;
            unsigned_q      <= 1'b0;
            wdata_q         <= '0;
            inst_ack_q      <= 1'b0;
            inst_err_q      <= 1'b0;
            data_ack_q      <= 1'b0;
            data_err_q      <= 1'b0;
            mem_address_q   <= '0;
            mem_write_q     <= 1'b0;
        end else begin
            inst_ack_q  <= 1'b0;
            inst_err_q  <= 1'b0;
            data_ack_q  <= 1'b0;
            data_err_q  <= 1'b0;
            mem_write_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_inst || pick_data) begin
                        grant_inst      <= pick_inst;
                        last_grant_inst <= pick_inst;
                        addr_lo_q       <= sel_addr[1:0];
                        size_q          <= pick_inst ? 2'b10 : bus.data_size;
                        unsigned_q      <= bus.data_unsigned;
                        wdata_q         <= bus.data_wdata;
                        if (sel_err) begin
                            state <= ERR;
                            if (pick_inst) begin
                                inst_ack_q <= 1'b1;
                                inst_err_q <= 1'b1;
                            end else begin
                                data_ack_q <= 1'b1;
                                data_err_q <= 1'b1;
                            end
                        end else if (pick_inst || !bus.data_write) begin
                            state         <= READ;
                            mem_address_q <= sel_addr;
                        end else if (bus.data_size == 2'b10) begin
                            state         <= WRITE;
                            mem_address_q <= sel_addr;
                            mem_write_q   <= 1'b1;
                            data_ack_q    <= 1'b1;
                        end else begin
                            state         <= RMW_READ;
                            mem_address_q <= sel_addr;
                        end
                    end
                end
                READ: begin
                    state <= RESP;
                    if (grant_inst) inst_ack_q <= 1'b1;
                    else            data_ack_q <= 1'b1;
                end
                RMW_READ: begin
                    state       <= RMW_WRITE;
                    mem_write_q <= 1'b1;
                    data_ack_q  <= 1'b1;
                end
                RESP, WRITE, RMW_WRITE, ERR: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Lane extraction and sign/zero extension of the word returned in RESP.
    always_comb begin
        case (addr_lo_q)
            2'b00:   byte_lane = bus.mem_output_data[7:0];
            2'b01:   byte_lane = bus.mem_output_data[15:8];
            2'b10:   byte_lane = bus.mem_output_data[23:16];
            default: byte_lane = bus.mem_output_data[31:24];
        endcase
        half_lane = addr_lo_q[1] ? bus.mem_output_data[31:16] : bus.mem_output_data[15:0];
        case (size_q)
            2'b00:   load_value = unsigned_q ? {24'h000000, byte_lane}
                                             : {{24{byte_lane[7]}}, byte_lane};
            2'b01:   load_value = unsigned_q ? {16'h0000, half_lane}
                                             : {{16{half_lane[15]}}, half_lane};
            default: load_value = bus.mem_output_data;
        endcase
    end

    // Read-modify-write merge: replace the addressed byte/half in the old word.
    always_comb begin
        if (size_q == 2'b00) begin
            lane_shift = {addr_lo_q, 3'b000};
            lane_mask  = 32'h0000_00FF << lane_shift;
            lane_data  = {24'h000000, wdata_q[7:0]} << lane_shift;
        end else begin
            lane_shift = {addr_lo_q[1], 4'b0000};
            lane_mask  = 32'h0000_FFFF << lane_shift;
            lane_data  = {16'h0000, wdata_q[15:0]} << lane_shift;
        end
        merged_word = (bus.mem_output_data & ~lane_mask) | lane_data;
    end

    // Read data and write data are combinational off the memory's registered
    // output, because that output only becomes valid in RESP / RMW_WRITE.
    always_comb begin
        bus.inst_data = (state == RESP && grant_inst) ? bus.mem_output_data : '0;
        bus.data_rdata = (state == RESP && !grant_inst) ? load_value : '0;
        case (state)
            WRITE:     bus.mem_input_data = wdata_q;
            RMW_WRITE: bus.mem_input_data = merged_word;
            default:   bus.mem_input_data = '0;
        endcase
    end

    assign bus.inst_ack         = inst_ack_q;
    assign bus.inst_err         = inst_err_q;
    assign bus.data_ack         = data_ack_q;
    assign bus.data_err         = data_err_q;
    assign bus.mem_address      = mem_address_q;
    assign bus.mem_should_write = mem_write_q;

endmodule

// File: tb/tb_memory_controller.sv
// Testbench for memory_controller: word memory model, byte-level reference
// model, directed cases and randomized load/store/fetch traffic.
module tb_memory_controller;

    logic clock;
    logic reset;
    logic mem_clear;

    int vectors;
    int miscompares;

    memory_controller_if bus ();

    memory_controller #(.MEM_SIZE_WORDS(256)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // word memory: registered read on the rising edge, write on the falling edge
    logic [31:0] mem [256];

    always @(posedge clock) bus.mem_output_data <= mem[bus.mem_address[9:2]];

    always @(negedge clock) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (bus.mem_should_write) begin
            mem[bus.mem_address[9:2]] <= bus.mem_input_data;
        end
    end

    // reference: memory as a flat array of bytes
    logic [7:0] ref_bytes [1024];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] base;
        base = {a[31:2], 2'b00};
        return {ref_bytes[base + 3], ref_bytes[base + 2], ref_bytes[base + 1], ref_bytes[base]};
    endfunction

    function automatic int unsigned size_bytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic ref_data_err(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if (a % size_bytes(sz) != 0) return 1'b1;
        return a >= 32'd1024;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
        int unsigned n;
        logic [31:0] v;
        n = size_bytes(sz);
        v = '0;
        for (int unsigned i = 0; i < n; i++) v = v | (32'(ref_bytes[a + i]) << (8 * i));
        if (!uns && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!uns && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        for (int unsigned i = 0; i < size_bytes(sz); i++) ref_bytes[a + i] = wd[8 * i +: 8];
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.inst_req = 1'b0;
        bus.data_req = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // One load/store through the data port, checked against the reference.
    task automatic data_txn(input logic wr, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd);
        int unsigned cyc, we_cnt, exp_lat;
        logic seen, overlap, er, exp_err;
        logic [31:0] rd, exp_rd;
        exp_err = ref_data_err(sz, a);
        exp_lat = exp_err ? 2 : (!wr ? 3 : (sz == 2'd2 ? 2 : 3));
        exp_rd  = (!exp_err && !wr) ? ref_load(sz, uns, a) : '0;
        bus.data_write    = wr;
        bus.data_size     = sz;
        bus.data_unsigned = uns;
        bus.data_address  = a;
        bus.data_wdata    = wd;
        bus.data_req      = 1'b1;
        cyc = 0; we_cnt = 0; seen = 0; overlap = 0; er = 0; rd = '0;
        while (!seen && cyc < 10) begin
            @(posedge clock); #1;
            cyc++;
            if (bus.mem_should_write) we_cnt++;
            if (bus.inst_ack) overlap = 1'b1;
            if (bus.data_ack) begin
                seen = 1'b1;
                rd   = bus.data_rdata;
                er   = bus.data_err;
            end else if (cyc == 1) begin
                // fields were latched at grant; scrambling them must not matter
                bus.data_address = $urandom;
                bus.data_wdata   = $urandom;
                bus.data_size    = 2'($urandom);
                bus.data_write   = 1'($urandom);
                bus.data_unsigned = 1'($urandom);
            end
        end
        check("data_ack_seen", 32'(seen), 1);
        if (seen) begin
            check("data_latency", cyc + 1, exp_lat);
            check("data_err", 32'(er), 32'(exp_err));
            check("data_rdata", rd, exp_rd);
        end
        @(posedge clock); #1;
        if (bus.mem_should_write) we_cnt++;
        check("data_ack_strobe", 32'(bus.data_ack), 0);
        check("data_no_inst_ack", 32'(overlap), 0);
        check("data_write_cycles", we_cnt, (wr && !exp_err) ? 1 : 0);
        bus.data_req = 1'b0;
        if (wr && !exp_err) ref_store(sz, a, wd);
    endtask

    // One fetch through the instruction port.
    task automatic inst_txn(input logic [31:0] a);
        int unsigned cyc, we_cnt;
        logic seen, overlap, er, exp_err;
        logic [31:0] rd;
        exp_err = (a[1:0] != 2'b00) || (a >= 32'd1024);
        bus.inst_address = a;
        bus.inst_req     = 1'b1;
        cyc = 0; we_cnt = 0; seen = 0; overlap = 0; er = 0; rd = '0;
        while (!seen && cyc < 10) begin
            @(posedge clock); #1;
            cyc++;
            if (bus.mem_should_write) we_cnt++;
            if (bus.data_ack) overlap = 1'b1;
            if (bus.inst_ack) begin
                seen = 1'b1;
                rd   = bus.inst_data;
                er   = bus.inst_err;
            end else if (cyc == 1) begin
                bus.inst_address = $urandom;
            end
        end
        check("inst_ack_seen", 32'(seen), 1);
        if (seen) begin
            check("inst_latency", cyc + 1, exp_err ? 2 : 3);
            check("inst_err", 32'(er), 32'(exp_err));
            check("inst_data", rd, exp_err ? 32'h0 : ref_word(a));
        end
        @(posedge clock); #1;
        check("inst_ack_strobe", 32'(bus.inst_ack), 0);
        check("inst_no_data_ack", 32'(overlap), 0);
        check("inst_no_write", we_cnt, 0);
        bus.inst_req = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned pick;
        pick = $urandom_range(0, 9);
        if (pick == 0) return 32'h400 + $urandom_range(0, 7);
        if (pick == 1) return 32'h3FC + $urandom_range(0, 3);
        return $urandom_range(0, 127);
    endfunction

    initial begin
        logic expect_inst, overlap;
        int unsigned acks;
        logic [31:0] saved;

        vectors = 0;
        miscompares = 0;
        mem_clear = 1'b1;
        bus.inst_address = '0;
        bus.data_write = 1'b0;
        bus.data_size = 2'd2;
        bus.data_unsigned = 1'b0;
        bus.data_address = '0;
        bus.data_wdata = '0;
        for (int i = 0; i < 1024; i++) ref_bytes[i] = 8'h00;

        reset = 1'b1;
        bus.inst_req = 1'b0;
        bus.data_req = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_inst_ack", 32'(bus.inst_ack), 0);
        check("rst_data_ack", 32'(bus.data_ack), 0);
        check("rst_errs", {30'h0, bus.inst_err, bus.data_err}, 0);
        check("rst_mem_write", 32'(bus.mem_should_write), 0);
        check("rst_mem_address", bus.mem_address, 0);
        check("rst_mem_input", bus.mem_input_data, 0);
        check("rst_inst_data", bus.inst_data, 0);
        check("rst_data_rdata", bus.data_rdata, 0);
        mem_clear = 1'b0;
        reset = 1'b0;

        // word store then load
        data_txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        check("word_store_mem", mem[4], 32'hDEAD_BEEF);
        data_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

        // sub-word read-modify-write
        data_txn(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344);
        data_txn(1'b1, 2'd0, 1'b0, 32'h22, 32'h0000_00AA);
        check("rmw_byte_word", mem[8], 32'h11AA_3344);
        data_txn(1'b1, 2'd1, 1'b0, 32'h20, 32'h0000_BEEF);
        check("rmw_half_word", mem[8], 32'h11AA_BEEF);
        data_txn(1'b0, 2'd0, 1'b0, 32'h22, 32'h0);
        data_txn(1'b0, 2'd0, 1'b1, 32'h22, 32'h0);
        data_txn(1'b0, 2'd1, 1'b0, 32'h20, 32'h0);
        inst_txn(32'h20);

        // error cases, none of which may touch memory
        data_txn(1'b0, 2'd1, 1'b0, 32'h21, 32'h0);
        inst_txn(32'h02);
        data_txn(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
        data_txn(1'b1, 2'd3, 1'b0, 32'h20, 32'hFFFF_FFFF);
        data_txn(1'b1, 2'd2, 1'b0, 32'h3FE, 32'hFFFF_FFFF);
        check("err_mem_intact", mem[8], 32'h11AA_BEEF);

        // contention from reset: fetch first, then alternate
        do_reset();
        bus.inst_address  = 32'h10;
        bus.data_write    = 1'b0;
        bus.data_size     = 2'd2;
        bus.data_address  = 32'h20;
        bus.inst_req      = 1'b1;
        bus.data_req      = 1'b1;
        expect_inst = 1'b1;
        overlap = 1'b0;
        acks = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock); #1;
            if (bus.inst_ack && bus.data_ack) overlap = 1'b1;
            if (bus.inst_ack) begin
                check("rr_order_inst", 32'(expect_inst), 1);
                check("rr_inst_data", bus.inst_data, ref_word(32'h10));
                expect_inst = 1'b0;
                acks++;
            end else if (bus.data_ack) begin
                check("rr_order_data", 32'(expect_inst), 0);
                check("rr_data_rdata", bus.data_rdata, ref_word(32'h20));
                expect_inst = 1'b1;
                acks++;
            end
        end
        bus.inst_req = 1'b0;
        bus.data_req = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("rr_no_overlap", 32'(overlap), 0);
        check("rr_enough_acks", 32'(acks >= 8), 1);

        // reset during RMW_READ of a byte store
        saved = ref_word(32'h24);
        bus.data_write    = 1'b1;
        bus.data_size     = 2'd0;
        bus.data_unsigned = 1'b0;
        bus.data_address  = 32'h25;
        bus.data_wdata    = 32'h0000_0055;
        bus.data_req      = 1'b1;
        @(posedge clock); #1;
        reset = 1'b1;
        bus.data_req = 1'b0;
        @(posedge clock); #1;
        check("mid_rst_outputs",
              {28'h0, bus.inst_ack, bus.data_ack, bus.mem_should_write, bus.inst_err | bus.data_err}, 0);
        check("mid_rst_mem_address", bus.mem_address, 0);
        check("mid_rst_mem_input", bus.mem_input_data, 0);
        check("mid_rst_rdata", bus.data_rdata | bus.inst_data, 0);
        reset = 1'b0;
        overlap = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
            if (bus.data_ack || bus.mem_should_write) overlap = 1'b1;
        end
        check("mid_rst_no_ack", 32'(overlap), 0);
        check("mid_rst_mem_word", mem[9], saved);
        data_txn(1'b0, 2'd2, 1'b0, 32'h24, 32'h0);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                inst_txn($urandom_range(0, 4) == 0 ? rand_addr() : {rand_addr()} & 32'hFFFF_FFFC);
            end else begin
                data_txn(1'($urandom), 2'($urandom_range(0, 7) == 0 ? 3 : $urandom_range(0, 2)),
                         1'($urandom), rand_addr(), $urandom);
            end
        end

        // whole memory against the byte-level reference
        for (int w = 0; w < 256; w++) check("final_mem", mem[w], ref_word(32'(w * 4)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/memory_controller.md
Name: memory_controller

Overview:
- Arbitrates and sequences access to the single-port word memory (registered read on rising edge, write on falling edge, index = address>>2) between the instruction-fetch port and the load/store data port.
- Performs sub-word accesses: byte/half loads with zero/sign extension, and byte/half stores by read-modify-write.
- Rejects misaligned and out-of-range accesses with an error response.
- Sits between the core pipeline and the memory module.

Parameters:
- MEM_SIZE_WORDS, 256, depth of the attached memory; byte addresses >= MEM_SIZE_WORDS*4 are errors.

Ports:
- clock  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- inst_req  in  1  fetch request; held until inst_ack.
- inst_address  in  32  fetch byte address.
- inst_ack  out  1  one-cycle response strobe.
- inst_data  out  32  fetched word; valid while inst_ack=1.
- inst_err  out  1  error; valid while inst_ack=1.
- data_req  in  1  load/store request; held until data_ack.
- data_write  in  1  1=store, 0=load.
- data_size  in  2  00 byte, 01 half, 10 word, 11 invalid.
- data_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend.
- data_address  in  32  byte address.
- data_wdata  in  32  store data; low bits used for sub-word stores.
- data_ack  out  1  one-cycle response strobe.
- data_rdata  out  32  extended load result; valid while data_ack=1 on loads, else 0.
- data_err  out  1  error; valid while data_ack=1.
- mem_address  out  32  to memory address.
- mem_input_data  out  32  to memory input_data.
- mem_should_write  out  1  to memory should_write.
- mem_output_data  in  32  from memory output_data.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all acks, errs, and mem_should_write are 0; mem_address, mem_input_data, inst_data, and data_rdata are 0; last_grant=DATA.
- Reset mid-transaction aborts it: no ack is issued and any pending RMW write is dropped.
- Requester fields (address, size, write, wdata) are latched at grant; later changes are ignored until ack.
- The requester must hold req until it sees ack. It may drop req in the ack cycle or keep it asserted to issue a new request.
- IDLE arbitration:
  - Only one port requesting: that port is granted.
  - Both requesting: the port that was not last_grant wins (round-robin); last_grant is updated on each grant.
- Error check at grant, in priority order: data_size=11; misaligned (half with addr[0]=1, word or inst with addr[1:0]!=0); address >= MEM_SIZE_WORDS*4. Any error -> ERR state.
- States and transitions:
  - IDLE -> READ (inst, or data load) | WRITE (word store) | RMW_READ (byte/half store) | ERR.
  - READ: mem_address driven, should_write=0 -> RESP.
  - RESP: mem_output_data valid. Ack the granted port with the word (inst) or the extracted, extended value (data) -> IDLE.
  - WRITE: mem_address, mem_input_data=wdata, should_write=1. Memory commits on the falling edge; data_ack=1 in this cycle -> IDLE.
  - RMW_READ: address driven -> RMW_WRITE.
  - RMW_WRITE: mem_input_data = mem_output_data with the selected byte/half lane replaced by wdata[7:0]/[15:0]. Lane = addr[1:0] for byte, addr[1] for half (little-endian). should_write=1, data_ack=1 -> IDLE.
  - ERR: ack the granted port with err=1, data outputs 0, no memory access -> IDLE.
- Latency from req sampled in IDLE to ack: read 3 cycles, word store 2, sub-word store 3, error 2.
- mem_should_write is asserted only in WRITE and RMW_WRITE.
- Ack is never asserted on both ports in the same cycle.
- Outside an active access, mem_address holds its last value.
- Load extraction:
  - Byte = word >> (8*addr[1:0]), bits [7:0].
  - Half = word >> (16*addr[1]), bits [15:0].
  - Sign- or zero-extended per data_unsigned. Word loads ignore data_unsigned.

Test Plan:
- Word store then load:
  - Store 0xDEADBEEF to 0x10: data_ack 2 cycles after req, mem_should_write high exactly 1 cycle.
  - Load word 0x10: data_ack on 3rd cycle, data_rdata=0xDEADBEEF, data_err=0.
- Sub-word RMW:
  - Preload 0x11223344 at 0x20.
  - Store byte 0xAA at 0x22 -> memory word 0x11AA3344.
  - Store half 0xBEEF at 0x20 -> 0x11AABEEF.
  - Load byte signed 0x22 -> 0xFFFFFFAA; unsigned -> 0x000000AA; load half signed 0x20 -> 0xFFFFBEEF.
- Contention:
  - inst_req and data_req asserted together from reset: inst granted first (last_grant=DATA), data next.
  - Both held continuously: grants alternate inst/data, acks never overlap.
- Errors, none touching memory (mem_should_write stays 0, memory contents unchanged):
  - Half load at 0x21 -> data_ack with data_err=1 after 2 cycles.
  - inst_address 0x02 -> inst_err=1.
  - Word load at 0x400 with MEM_SIZE_WORDS=256 -> err.
  - data_size=11 -> err.
- Reset mid-RMW: assert reset during RMW_READ of a byte store -> no ack, memory word unchanged, all outputs 0 next cycle, state IDLE.
